wrr_prio_arbiter: RTL and testbench

Parametrised weighted round-robin arbiter with an integrated per-requester priority (weight) table and a priority-update handshake port. It generalises the fixed 32-requester / 4-bit priority-update path to any requester count and weight width. It adds credit-based weighted granting, weight-0 disable, and out-of-range update error reporting. It sits between the requester bank and the shared resource, and is programmed by the priority-update agent.

---
 rtl/wrr_prio_arbiter.sv | 159 +++++++++++++++
 tb/tb_wrr_prio_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/wrr_prio_arbiter.sv
// Weighted round-robin arbiter with per-requester weight/credit table and a priority-update handshake.
// Optional macro WRR_GNT_REG_EN registers gnt/gnt_vld/gnt_id; default build drives them combinationally.
module wrr_prio_arbiter #(
   parameter int N_REQ      = 32,
   parameter int PRIO_W     = 4,
   parameter int RESET_PRIO = 1,
   parameter int ID_W       = $clog2(N_REQ)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_REQ-1:0]  req,
   output logic [N_REQ-1:0]  gnt,
   output logic              gnt_vld,
   output logic [ID_W-1:0]   gnt_id,
   input  logic              prio_upt,
   input  logic [ID_W-1:0]   prio_id,
   input  logic [PRIO_W-1:0] prio,
   output logic              ack,
   output logic              prio_err
);

   logic [PRIO_W-1:0] w_q   [N_REQ];
   logic [PRIO_W-1:0] c_q   [N_REQ];
   logic [PRIO_W-1:0] c_nxt [N_REQ];
   logic [PRIO_W-1:0] c_wr  [N_REQ];
   logic [ID_W-1:0]   ptr_q;
   logic [ID_W-1:0]   ptr_nxt;
   logic              ack_q;
   logic              err_q;

   logic [N_REQ-1:0]  active;
   logic [N_REQ-1:0]  eligible;
   logic              found;
   logic [ID_W-1:0]   k;
   logic              hi_f;
   logic              lo_f;
   logic [ID_W-1:0]   hi_k;
   logic [ID_W-1:0]   lo_k;
   logic              do_reload;
   logic              accept;
   logic              in_range;
   logic              wr_en;
   logic [N_REQ-1:0]  gnt_comb;

   always_comb begin
      active   = '0;
      eligible = '0;
      for (int i = 0; i < N_REQ; i++) begin
         active[i]   = req[i] & (w_q[i] != '0);
         eligible[i] = active[i] & (c_q[i] != '0);
      end
   end

   // Rotating search: lowest eligible index at or above ptr, else lowest eligible overall.
   always_comb begin
      hi_f = 1'b0;
      lo_f = 1'b0;
      hi_k = '0;
      lo_k = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (eligible[i] && !lo_f) begin
            lo_f = 1'b1;
            lo_k = ID_W'(i);
         end
         if (eligible[i] && !hi_f && (ID_W'(i) >= ptr_q)) begin
            hi_f = 1'b1;
            hi_k = ID_W'(i);
         end
      end
      found = lo_f;
      k     = hi_f ? hi_k : lo_k;
   end

   assign do_reload = !found && (active != '0);
   assign in_range  = ({1'b0, prio_id} < (ID_W+1)'(N_REQ));
   assign accept    = prio_upt & ~ack_q;
   assign wr_en     = accept & in_range;

   always_comb begin
      ptr_nxt = ptr_q;
      if (found) begin
         if (c_q[k] != PRIO_W'(1))
            ptr_nxt = k;
         else if (k == ID_W'(N_REQ-1))
            ptr_nxt = '0;
         else
            ptr_nxt = k + ID_W'(1);
      end
   end

   // Grant/reload first, then the update clamps the result so a weight cut never leaves excess credit.
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         if (found && (k == ID_W'(i)))
            c_nxt[i] = c_q[i] - PRIO_W'(1);
         else if (do_reload)
            c_nxt[i] = w_q[i];
         else
            c_nxt[i] = c_q[i];
         if (wr_en && (prio_id == ID_W'(i)))
            c_wr[i] = (c_nxt[i] < prio) ? c_nxt[i] : prio;
         else
            c_wr[i] = c_nxt[i];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N_REQ; i++) begin
            w_q[i] <= PRIO_W'(RESET_PRIO);
            c_q[i] <= PRIO_W'(RESET_PRIO);
         end
         ptr_q <= '0;
         ack_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            c_q[i] <= c_wr[i];
            if (wr_en && (prio_id == ID_W'(i)))
               w_q[i] <= prio;
         end
         ptr_q <= ptr_nxt;
         ack_q <= accept;
         err_q <= accept & ~in_range;
      end
   end

   assign ack      = ack_q;
   assign prio_err = err_q;
   assign gnt_comb = found ? (N_REQ'(1) << k) : '0;

`ifdef WRR_GNT_REG_EN
   logic [N_REQ-1:0] gnt_q;
   logic             vld_q;
   logic [ID_W-1:0]  id_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gnt_q <= '0;
         vld_q <= 1'b0;
         id_q  <= '0;
      end else begin
         gnt_q <= gnt_comb;
         vld_q <= found;
         id_q  <= found ? k : '0;
      end
   end

   assign gnt     = gnt_q;
   assign gnt_vld = vld_q;
   assign gnt_id  = id_q;
`else
   // Gated by rst so the outputs clear immediately on asynchronous reset assertion.
   assign gnt     = rst ? gnt_comb : '0;
   assign gnt_vld = found & rst;
   assign gnt_id  = (found & rst) ? k : '0;
`endif

endmodule

// File: tb/tb_wrr_prio_arbiter.sv
// Scoreboard bench for wrr_prio_arbiter (default build): a 4-requester and a 6-requester instance.
module tb_wrr_prio_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   always #5 clk = ~clk;

   logic [3:0] req4, gnt4, prio4;
   logic       vld4, upt4, ack4, err4;
   logic [1:0] gid4, pid4;
   logic [5:0] req6, gnt6;
   logic [3:0] prio6;
   logic       vld6, upt6, ack6, err6;
   logic [2:0] gid6, pid6;

   wrr_prio_arbiter #(.N_REQ(4), .PRIO_W(4), .RESET_PRIO(1)) dut (
      .clk(clk), .rst(rst), .req(req4), .gnt(gnt4), .gnt_vld(vld4), .gnt_id(gid4),
      .prio_upt(upt4), .prio_id(pid4), .prio(prio4), .ack(ack4), .prio_err(err4));

   wrr_prio_arbiter #(.N_REQ(6), .PRIO_W(4), .RESET_PRIO(1)) dut6 (
      .clk(clk), .rst(rst), .req(req6), .gnt(gnt6), .gnt_vld(vld6), .gnt_id(gid6),
      .prio_upt(upt6), .prio_id(pid6), .prio(prio6), .ack(ack6), .prio_err(err6));

   typedef struct {
      bit    sel;
      bit    vld;
      int    id;
      bit    ack;
      bit    err;
      string name;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   function automatic logic [15:0] pack(input bit sel);
      if (!sel) return {4'b0, vld4, 1'b0, gid4, 2'b0, gnt4, ack4, err4};
      return {4'b0, vld6, gid6, gnt6, ack6, err6};
   endfunction

   function automatic logic [15:0] exp_pack(input exp_t e);
      logic [5:0] g;
      g = e.vld ? 6'(1 << e.id) : 6'd0;
      return {4'b0, e.vld, 3'(e.id), g, e.ack, e.err};
   endfunction

   function automatic void chk(input string nm, input logic [15:0] got, input logic [15:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h (vld,id,gnt,ack,err)", nm, got, want);
      end
   endfunction

   task automatic cyc(input bit sel, input logic [5:0] r, input logic upt, input logic [2:0] id,
                      input logic [3:0] p, input int eid, input bit ea, input bit ee, input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      if (!sel) begin
         req4 = r[3:0]; upt4 = upt; pid4 = id[1:0]; prio4 = p;
         req6 = 6'h0;   upt6 = 1'b0;
      end else begin
         req6 = r;      upt6 = upt; pid6 = id; prio6 = p;
         req4 = 4'h0;   upt4 = 1'b0;
      end
      e.sel  = sel;
      e.vld  = (eid >= 0);
      e.id   = (eid >= 0) ? eid : 0;
      e.ack  = ea;
      e.err  = ee;
      e.name = nm;
      q.push_back(e);
   endtask

   task automatic grants(input bit sel, input logic [5:0] r, input int s[], input string nm);
      foreach (s[i]) cyc(sel, r, 1'b0, 3'd0, 4'd0, s[i], 1'b0, 1'b0, nm);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk(e.name, pack(e.sel), exp_pack(e));
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "bench timeout");
   end

   initial begin : stim
      int seq[];
      rst = 1'b0;
      req4 = 4'h0; upt4 = 1'b0; pid4 = 2'd0; prio4 = 4'd0;
      req6 = 6'h0; upt6 = 1'b0; pid6 = 3'd0; prio6 = 4'd0;
      #3;
      chk("reset4", pack(1'b0), 16'h0);
      chk("reset6", pack(1'b1), 16'h0);
      @(negedge clk);
      rst = 1'b1;

      seq = '{0, 1, 2, 3, -1, 0, 1, 2, 3, -1};
      grants(1'b0, 6'h0f, seq, "wrr_equal");

      cyc(1'b0, 6'h00, 1'b1, 3'd2, 4'd3, -1, 1'b0, 1'b0, "upd_accept");
      cyc(1'b0, 6'h00, 1'b0, 3'd0, 4'd0, -1, 1'b1, 1'b0, "upd_ack");
      seq = '{1, 2, -1, 1, 2, 2, 2, -1, 1, 2, 2, 2};
      grants(1'b0, 6'h06, seq, "upd_arb");

      cyc(1'b0, 6'h00, 1'b1, 3'd1, 4'd0, -1, 1'b0, 1'b0, "dis_accept");
      cyc(1'b0, 6'h00, 1'b0, 3'd0, 4'd0, -1, 1'b1, 1'b0, "dis_ack");
      seq = '{0, -1, 0};
      grants(1'b0, 6'h03, seq, "dis_req01");
      seq = '{-1, -1, -1};
      grants(1'b0, 6'h02, seq, "dis_idle");
      // c0 was left at 0 before the idle stretch, so a bubble must come first
      seq = '{-1, 0};
      grants(1'b0, 6'h01, seq, "dis_nochg");

      cyc(1'b0, 6'h04, 1'b1, 3'd2, 4'd1, 2, 1'b0, 1'b0, "clamp_upd");
      cyc(1'b0, 6'h04, 1'b0, 3'd0, 4'd0, 2, 1'b1, 1'b0, "clamp_ack");
      seq = '{-1, 2, -1, 2};
      grants(1'b0, 6'h04, seq, "clamp_after");

      cyc(1'b0, 6'h00, 1'b1, 3'd3, 4'd1, -1, 1'b0, 1'b0, "rst_upd");
      cyc(1'b0, 6'h0f, 1'b0, 3'd0, 4'd0, 3, 1'b1, 1'b0, "rst_busy");
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("rst_async4", pack(1'b0), 16'h0);
      chk("rst_async6", pack(1'b1), 16'h0);
      req4 = 4'h0;
      @(negedge clk);
      rst = 1'b1;
      seq = '{1, 2, 3, -1, 1};
      grants(1'b0, 6'h0e, seq, "rst_first");

      cyc(1'b1, 6'h00, 1'b1, 3'd7, 4'd5, -1, 1'b0, 1'b0, "oor_accept");
      cyc(1'b1, 6'h00, 1'b1, 3'd7, 4'd5, -1, 1'b1, 1'b1, "oor_ack");
      cyc(1'b1, 6'h00, 1'b0, 3'd0, 4'd0, -1, 1'b0, 1'b0, "oor_no2nd");
      seq = '{0, 1, 2, 3, 4, 5, -1, 0, 1, 2, 3, 4, 5, -1};
      grants(1'b1, 6'h3f, seq, "oor_weights");

      @(posedge clk);
      #1;
      req6 = 6'h0;
      @(negedge clk);
      @(negedge clk);
      chk("sb_drained", 16'(q.size()), 16'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
